spart_ctrl: RTL and testbench

Bus-side controller for the SPART serial port. It decodes processor I/O accesses (`iocs`/`iorw`/`ioaddr`) into data, status and divisor registers, and generates the per-bit `baud_en` strobe shared by the transmitter and receiver. It buffers received bytes for the processor and sequences single-byte transfers into the transmitter. It sits between the processor bus and the `spart` transmitter/receiver datapaths.

---
 rtl/spart_pkg.sv | 22 ++
 rtl/spart_if.sv | 22 ++
 rtl/spart_baud_gen.sv | 47 ++++
 rtl/spart_ctrl.sv | 179 +++++++++++++++++
 tb/tb_spart_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spart_pkg.sv
// SPART controller shared definitions: register map, status bits,
// TX sequencer states and the reset divisor.
package spart_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'b00;
   localparam logic [1:0] ADDR_STATUS = 2'b01;
   localparam logic [1:0] ADDR_DB_LO  = 2'b10;
   localparam logic [1:0] ADDR_DB_HI  = 2'b11;

   localparam int ST_RDA = 0;
   localparam int ST_TBR = 1;
   localparam int ST_OVR = 2;

   localparam logic [15:0] DEFAULT_DIV = 16'd5207;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_LOAD,
      TX_WAIT
   } tx_state_e;

endpackage

// File: rtl/spart_if.sv
// Processor I/O bus between the CPU (master) and the SPART
// controller (slave).
interface spart_if;

   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic [7:0] databus_in;
   logic [7:0] databus_out;
   logic       databus_oe;

   modport master (
      output iocs, iorw, ioaddr, databus_in,
      input  databus_out, databus_oe
   );

   modport slave (
      input  iocs, iorw, ioaddr, databus_in,
      output databus_out, databus_oe
   );

endinterface

// File: rtl/spart_baud_gen.sv
// Divisor register and bit-time down-counter producing baud_en.
// A divisor write restarts the count from the new value.
module spart_baud_gen
   import spart_pkg::*;
#(
   parameter logic [15:0] DEFAULT_DIVISOR = DEFAULT_DIV
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [7:0]  wdata,
   output logic [15:0] divisor,
   output logic        baud_en
);

   logic [15:0] cnt;
   logic [15:0] div_nx;
   logic        reload;

   always_comb begin
      div_nx = divisor;
      if (wr_lo) div_nx[7:0]  = wdata;
      if (wr_hi) div_nx[15:8] = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divisor <= DEFAULT_DIVISOR;
         cnt     <= DEFAULT_DIVISOR;
         reload  <= 1'b0;
      end else begin
         divisor <= div_nx;
         reload  <= wr_lo | wr_hi;
         if (wr_lo | wr_hi)
            cnt <= div_nx;
         else if (cnt == 16'd0)
            cnt <= divisor;
         else
            cnt <= cnt - 16'd1;
      end
   end

   // reload masks the pulse when a new divisor of 0 lands
   assign baud_en = (cnt == 16'd0) & ~reload;

endmodule

// File: rtl/spart_ctrl.sv
// SPART bus controller: register decode, RX buffering, TX sequencing.
// Define SPART_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO.
module spart_ctrl
   import spart_pkg::*;
#(
   parameter logic [15:0] DEFAULT_DIVISOR = DEFAULT_DIV
`ifdef SPART_RX_FIFO_EN
   , parameter int RX_DEPTH = 4
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   spart_if.slave     bus,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       baud_en,
   output logic       rda,
   output logic       tbr
);

   logic rd, wr;
   logic rd_dat, rd_st, rd_lo, rd_hi;
   logic wr_dat, wr_lo, wr_hi;
   logic pop, push_ok, full, have, ovr;
   logic [7:0] head, rdata, stat;
   logic [15:0] divisor;

   assign rd     = bus.iocs & bus.iorw;
   assign wr     = bus.iocs & ~bus.iorw;
   assign rd_dat = rd & (bus.ioaddr == ADDR_DATA);
   assign rd_st  = rd & (bus.ioaddr == ADDR_STATUS);
   assign rd_lo  = rd & (bus.ioaddr == ADDR_DB_LO);
   assign rd_hi  = rd & (bus.ioaddr == ADDR_DB_HI);
   assign wr_dat = wr & (bus.ioaddr == ADDR_DATA);
   assign wr_lo  = wr & (bus.ioaddr == ADDR_DB_LO);
   assign wr_hi  = wr & (bus.ioaddr == ADDR_DB_HI);

   assign pop     = rd_dat & have;
   assign push_ok = rx_valid & (~full | pop);

`ifdef SPART_RX_FIFO_EN
   localparam int AW = $clog2(RX_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(RX_DEPTH);

   logic [7:0]    mem [RX_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push_ok) begin
            mem[wp] <= rx_data;
            wp      <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
         case ({push_ok, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign full = (cnt == FULL_CNT);
   assign have = (cnt != '0);
   assign head = mem[rp];
`else
   logic [7:0] rx_buf;
   logic       rx_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_buf  <= '0;
         rx_full <= 1'b0;
      end else if (push_ok) begin
         rx_buf  <= rx_data;
         rx_full <= 1'b1;
      end else if (pop) begin
         rx_full <= 1'b0;
      end
   end

   assign full = rx_full;
   assign have = rx_full;
   assign head = rx_buf;
`endif

   assign rda = have;

   // a set in the same cycle as a status read wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovr <= 1'b0;
      else if (rx_valid & full & ~pop)
         ovr <= 1'b1;
      else if (rd_st)
         ovr <= 1'b0;
   end

   always_comb begin
      stat         = '0;
      stat[ST_RDA] = rda;
      stat[ST_TBR] = tbr;
      stat[ST_OVR] = ovr;
   end

   always_comb begin
      rdata = '0;
      unique case (1'b1)
         rd_dat:  rdata = have ? head : 8'h00;
         rd_st:   rdata = stat;
         rd_lo:   rdata = divisor[7:0];
         rd_hi:   rdata = divisor[15:8];
         default: rdata = '0;
      endcase
   end

   assign bus.databus_out = rdata;
   assign bus.databus_oe  = rd;

   tx_state_e  state;
   logic [7:0] hold;
   logic       hold_full, hold_ld;

   assign hold_ld = wr_dat & ~hold_full;
   assign tbr     = ~hold_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= TX_IDLE;
         hold      <= '0;
         hold_full <= 1'b0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
      end else begin
         tx_start <= 1'b0;
         if (hold_ld) begin
            hold      <= bus.databus_in;
            hold_full <= 1'b1;
         end
         unique case (state)
            TX_IDLE:
               if ((hold_full | hold_ld) & ~tx_busy) begin
                  state    <= TX_LOAD;
                  tx_start <= 1'b1;
                  tx_data  <= hold_full ? hold : bus.databus_in;
               end
            TX_LOAD: begin
               hold_full <= 1'b0;
               state     <= TX_WAIT;
            end
            TX_WAIT:
               if (tx_busy) state <= TX_IDLE;
            default: state <= TX_IDLE;
         endcase
      end
   end

   spart_baud_gen #(
      .DEFAULT_DIVISOR(DEFAULT_DIVISOR)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_lo   (wr_lo),
      .wr_hi   (wr_hi),
      .wdata   (bus.databus_in),
      .divisor (divisor),
      .baud_en (baud_en)
   );

endmodule

// File: tb/tb_spart_ctrl.sv
// Scoreboard bench for spart_ctrl: cycle-level reference model,
// directed scenarios plus randomized bus and RX traffic.
module tb_spart_ctrl;
   import spart_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spart_if bus();

   logic [7:0] tx_data, rx_data;
   logic tx_start, tx_busy, rx_valid;
   logic baud_en, rda, tbr;

   spart_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .baud_en  (baud_en),
      .rda      (rda),
      .tbr      (tbr)
   );

`ifdef SPART_RX_FIFO_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 1;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference model state
   logic [7:0]  rxq[$];
   bit          m_ovr;
   logic [15:0] m_div;
   bit          w_known;
   int          w_cyc;
   int          s0, k0, s1, k1;
   int          h_start, h_end;

   // scoreboard queues
   logic [7:0] rdq[$];
   logic [7:0] txd[$];
   int         txc[$];

   bit   chk_en;
   logic e_tbr, e_rda, e_oe, e_baud;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h cyc %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic bit busy_at(int c);
      return (c >= s0 + 1 && c <= s0 + k0) ||
             (c >= s1 + 1 && c <= s1 + k1);
   endfunction

   task automatic model_reset();
      rxq.delete();
      rdq.delete();
      txd.delete();
      txc.delete();
      m_ovr   = 0;
      m_div   = 16'd5207;
      w_known = 0;
      w_cyc   = 0;
      s0 = -100; k0 = 0;
      s1 = -100; k1 = 0;
      h_start = -100;
      h_end   = -100;
   endtask

   task automatic step(bit cs, bit rw, logic [1:0] a,
                       logic [7:0] din, bit rv, logic [7:0] rd);
      int c, d, e;
      bit tbr_m, ovs;
      logic [7:0] st;
      c     = cyc;
      tbr_m = !(c >= h_start && c <= h_end);
      bus.iocs       = cs;
      bus.iorw       = rw;
      bus.ioaddr     = a;
      bus.databus_in = din;
      rx_valid       = rv;
      rx_data        = rd;
      tx_busy        = busy_at(c);
      e_tbr = tbr_m;
      e_rda = (rxq.size() != 0);
      e_oe  = cs && rw;
      d = int'(m_div);
      e_baud = w_known && ((c - w_cyc - 1) % (d + 1) == d) &&
               (c != w_cyc + 1);
      if (cs && rw) begin
         st = {5'b0, m_ovr, tbr_m, rxq.size() != 0};
         case (a)
            2'd0: rdq.push_back(rxq.size() != 0 ? rxq[0] : 8'h00);
            2'd1: rdq.push_back(st);
            2'd2: rdq.push_back(m_div[7:0]);
            default: rdq.push_back(m_div[15:8]);
         endcase
      end
      if (cs && rw && a == 2'd0 && rxq.size() != 0)
         void'(rxq.pop_front());
      ovs = 0;
      if (rv) begin
         if (rxq.size() == CAP) ovs = 1;
         else rxq.push_back(rd);
      end
      if (ovs) m_ovr = 1;
      else if (cs && rw && a == 2'd1) m_ovr = 0;
      if (cs && !rw) begin
         case (a)
            2'd0: if (tbr_m) begin
               e = (c > s1 + k1 + 1) ? c : s1 + k1 + 1;
               s0 = s1; k0 = k1;
               s1 = e + 1;
               k1 = int'($urandom_range(1, 5));
               h_start = c + 1;
               h_end   = s1;
               txc.push_back(s1);
               txd.push_back(din);
            end
            2'd2: begin m_div[7:0] = din; w_cyc = c; w_known = 1; end
            2'd3: begin m_div[15:8] = din; w_cyc = c; w_known = 1; end
            default: ;
         endcase
      end
      chk_en = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 2'd0, 8'h00, 0, 8'h00);
   endtask

   task automatic rd_reg(logic [1:0] a);
      step(1, 1, a, 8'h00, 0, 8'h00);
   endtask

   task automatic wr_reg(logic [1:0] a, logic [7:0] v);
      step(1, 0, a, v, 0, 8'h00);
   endtask

   task automatic push(logic [7:0] v);
      step(0, 0, 2'd0, 8'h00, 1, v);
   endtask

   task automatic reset_outputs(string tag);
      check({tag, "_oe"}, bus.databus_oe, 0);
      check({tag, "_out"}, bus.databus_out, 0);
      check({tag, "_start"}, tx_start, 0);
      check({tag, "_txd"}, tx_data, 0);
      check({tag, "_baud"}, baud_en, 0);
      check({tag, "_rda"}, rda, 0);
      check({tag, "_tbr"}, tbr, 1);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("tbr", tbr, e_tbr);
         check("rda", rda, e_rda);
         check("oe", bus.databus_oe, e_oe);
         check("baud_en", baud_en, e_baud);
         if (bus.databus_oe) begin
            if (rdq.size() == 0) check("rd_extra", 1, 0);
            else check("rdata", bus.databus_out, rdq.pop_front());
         end
         if (tx_start) begin
            if (txc.size() == 0) begin
               check("tx_extra", 1, 0);
            end else begin
               check("tx_data", tx_data, txd.pop_front());
               check("tx_cyc", cyc, txc.pop_front());
            end
         end
      end
   end

   initial begin
      chk_en = 0;
      bus.iocs = 0; bus.iorw = 0; bus.ioaddr = 0; bus.databus_in = 0;
      rx_valid = 0; rx_data = 0; tx_busy = 0;
      model_reset();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      reset_outputs("rst");
      rst_n = 1;
      @(posedge clk);
      #1;

      rd_reg(2'd2); rd_reg(2'd3); rd_reg(2'd1); rd_reg(2'd0);

      wr_reg(2'd2, 8'd3); wr_reg(2'd3, 8'd0);
      idle(12);

      wr_reg(2'd0, 8'hA5);
      idle(1);
      wr_reg(2'd0, 8'h5A);
      wr_reg(2'd0, 8'h77);
      idle(10);

      push(8'h3C); rd_reg(2'd0); idle(1); rd_reg(2'd0);

      for (int i = 1; i <= 5; i++) push(8'(i));
      for (int i = 0; i < 4; i++) rd_reg(2'd0);
      rd_reg(2'd1); rd_reg(2'd1);

      push(8'hAA);
      step(1, 1, 2'd0, 8'h00, 1, 8'hBB);
      rd_reg(2'd1); rd_reg(2'd0); rd_reg(2'd0);

      wr_reg(2'd2, 8'd0); idle(4);
      wr_reg(2'd2, 8'd2); idle(6);

      for (int i = 0; i < 800; i++) begin
         bit cs, rw, rv;
         logic [1:0] a;
         logic [7:0] v;
         cs = ($urandom_range(0, 1) == 1);
         rw = ($urandom_range(0, 1) == 1);
         a  = 2'($urandom_range(0, 3));
         v  = 8'($urandom);
         if (!rw && a == 2'd3 && $urandom_range(0, 3) != 0) v = 8'h00;
         if (!rw && a == 2'd2) v = v & 8'h07;
         rv = ($urandom_range(0, 3) == 0);
         step(cs, rw, a, v, rv, 8'($urandom));
      end
      idle(20);

      push(8'h11);
      wr_reg(2'd0, 8'h99);
      idle(2);
      chk_en = 0;
      rst_n = 0;
      #1;
      reset_outputs("midrst");
      model_reset();
      tx_busy = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      @(posedge clk);
      #1;
      idle(10);
      rd_reg(2'd1); rd_reg(2'd2); rd_reg(2'd0);
      idle(2);

      chk_en = 0;
      check("rdq_left", rdq.size(), 0);
      check("txq_left", txc.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
